// File: rtl/lfsr_pkg.sv
// Shared definitions for the lfsr_gen sequence source: mode encoding and
// default maximal-length feedback masks.
package lfsr_pkg;

   typedef enum logic {
      FIBONACCI = 1'b0,
      GALOIS    = 1'b1
   } lfsr_mode_e;

   // Bit k of the mask is the polynomial term x^(k+1); all entries are primitive.
   function automatic logic [31:0] default_taps(input int width);
      logic [31:0] taps;
      case (width)
         3:       taps = 32'h0000_0006;
         4:       taps = 32'h0000_000C;
         5:       taps = 32'h0000_0014;
         6:       taps = 32'h0000_0030;
         7:       taps = 32'h0000_0060;
         8:       taps = 32'h0000_00B8;
         9:       taps = 32'h0000_0110;
         10:      taps = 32'h0000_0240;
         11:      taps = 32'h0000_0500;
         12:      taps = 32'h0000_0829;
         13:      taps = 32'h0000_100D;
         14:      taps = 32'h0000_2015;
         15:      taps = 32'h0000_6000;
         16:      taps = 32'h0000_B400;
         17:      taps = 32'h0001_2000;
         18:      taps = 32'h0002_0400;
         19:      taps = 32'h0004_0023;
         20:      taps = 32'h0009_0000;
         21:      taps = 32'h0014_0000;
         22:      taps = 32'h0030_0000;
         23:      taps = 32'h0042_0000;
         24:      taps = 32'h00E1_0000;
         25:      taps = 32'h0120_0000;
         26:      taps = 32'h0200_0023;
         27:      taps = 32'h0400_0013;
         28:      taps = 32'h0900_0000;
         29:      taps = 32'h1400_0000;
         30:      taps = 32'h2000_0029;
         31:      taps = 32'h4800_0000;
         32:      taps = 32'h8020_0003;
         default: taps = 32'h0000_0000;
      endcase
      return taps;
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state function of the LFSR in either Fibonacci or
// Galois form, plus an all-zero detect for lockup recovery.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] taps,
   input  logic             mode,
   output logic [WIDTH-1:0] next,
   output logic             is_zero
);

   always_comb begin
      // NOTE: default assignment first so no path through the block leaves next unassigned (no latch).
      next = '0;
      if (lfsr_mode_e'(mode) == GALOIS) begin
         next = {1'b0, state[WIDTH-1:1]} ^ ({WIDTH{state[0]}} & taps);
      end else begin
         next = {state[WIDTH-2:0], ^(state & taps)};
      end
   end

   assign is_zero = (state == '0);

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR sequence source with seed load, runtime mode select,
// all-zero lockup recovery and period tracking against a reference seed.
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int          WIDTH      = 4,
   parameter logic [31:0] TAPS       = 32'd0,
   parameter logic [31:0] RESET_SEED = 32'd1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   input  logic             mode,
   output logic [WIDTH-1:0] out,
   output logic             bit_out,
   output logic [WIDTH-1:0] step_cnt,
   output logic             period_done,
   output logic             lockup
);

   localparam logic [31:0]      TAPS_ALL = (TAPS == 32'd0) ? default_taps(WIDTH) : TAPS;
   localparam logic [WIDTH-1:0] TAPS_EFF = TAPS_ALL[WIDTH-1:0];
   localparam logic [WIDTH-1:0] SEED     = RESET_SEED[WIDTH-1:0];

   if (WIDTH < 3 || WIDTH > 32) begin : g_bad_width
      $error("lfsr_gen: WIDTH must be in 3..32");
   end
   if (SEED == '0) begin : g_bad_seed
      $error("lfsr_gen: RESET_SEED must be nonzero");
   end

   logic [WIDTH-1:0] state;
   logic [WIDTH-1:0] ref_seed;
   logic             mode_q;
   logic [WIDTH-1:0] next;
   logic             is_zero;

   lfsr_next #(.WIDTH(WIDTH)) u_next (
      .state   (state),
      .taps    (TAPS_EFF),
      .mode    (mode_q),
      .next    (next),
      .is_zero (is_zero)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= SEED;
         ref_seed    <= SEED;
         mode_q      <= 1'b0;
         step_cnt    <= '0;
         period_done <= 1'b0;
         lockup      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         period_done <= 1'b0;
         lockup      <= 1'b0;
         if (load) begin
            state    <= seed_in;
            ref_seed <= seed_in;
            step_cnt <= '0;
            mode_q   <= mode;
         end else if (mode != mode_q) begin
            // Resync: the current state becomes the new period reference.
            mode_q   <= mode;
            ref_seed <= state;
            step_cnt <= '0;
         end else if (en) begin
            if (is_zero) begin
               state    <= SEED;
               ref_seed <= SEED;
               step_cnt <= '0;
               lockup   <= 1'b1;
            end else begin
               state <= next;
               if (next == ref_seed) begin
                  step_cnt    <= '0;
                  period_done <= 1'b1;
               end else begin
                  step_cnt <= step_cnt + 1'b1;
               end
            end
         end
      end
   end

   assign out     = state;
   assign bit_out = (lfsr_mode_e'(mode_q) == GALOIS) ? state[0] : state[WIDTH-1];

endmodule

// File: tb/tb_lfsr_gen.sv
// Scoreboard bench for lfsr_gen: a 4-bit and a 16-bit instance checked
// against an arithmetic reference model plus directed sequence vectors.
module tb_lfsr_gen;

   typedef struct {
      logic [31:0] out;
      logic [31:0] cnt;
      logic        pd;
      logic        lk;
      logic        bo;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        load4, en4, mode4;
   logic [3:0]  seed4;
   logic [3:0]  out4, cnt4;
   logic        bo4, pd4, lk4;
   logic        load16, en16, mode16;
   logic [15:0] seed16;
   logic [15:0] out16, cnt16;
   logic        bo16, pd16, lk16;

   int n_checks = 0;
   int n_err    = 0;

   exp_t sb0[$];
   exp_t sb1[$];

   int wid_of[2]  = '{4, 16};
   int taps_of[2] = '{'hC, 'hB400};
   int m_state[2];
   int m_ref[2];
   int m_cnt[2];
   bit m_mode[2];
   int pd16_seen = 0;
   int lk16_seen = 0;

   always #5 clk = ~clk;

   lfsr_gen #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .en(en4), .load(load4), .seed_in(seed4), .mode(mode4),
      .out(out4), .bit_out(bo4), .step_cnt(cnt4), .period_done(pd4), .lockup(lk4)
   );

   lfsr_gen #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .en(en16), .load(load16), .seed_in(seed16), .mode(mode16),
      .out(out16), .bit_out(bo16), .step_cnt(cnt16), .period_done(pd16), .lockup(lk16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   function automatic int model_next(input int s, input int w, input int taps, input bit galois);
      int msk;
      msk = (1 << w) - 1;
      if (galois) return (s >> 1) ^ (((s & 1) != 0) ? taps : 0);
      return ((s << 1) | ($countones(s & taps) & 1)) & msk;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_state[i] = 1;
         m_ref[i]   = 1;
         m_cnt[i]   = 0;
         m_mode[i]  = 1'b0;
      end
   endfunction

   // Apply one cycle of stimulus to instance id and queue the expected response.
   task automatic drive(input int id, input bit l, input bit e, input int s, input bit md);
      exp_t x;
      int   w, msk;
      bit   pd, lk;
      w   = wid_of[id];
      msk = (1 << w) - 1;
      pd  = 1'b0;
      lk  = 1'b0;
      @(negedge clk);
      if (id == 0) begin
         load4 = l; en4 = e; seed4 = s[3:0]; mode4 = md;
      end else begin
         load16 = l; en16 = e; seed16 = s[15:0]; mode16 = md;
      end
      if (l) begin
         m_state[id] = s & msk;
         m_ref[id]   = s & msk;
         m_cnt[id]   = 0;
         m_mode[id]  = md;
      end else if (md != m_mode[id]) begin
         m_mode[id] = md;
         m_ref[id]  = m_state[id];
         m_cnt[id]  = 0;
      end else if (e) begin
         if (m_state[id] == 0) begin
            m_state[id] = 1;
            m_ref[id]   = 1;
            m_cnt[id]   = 0;
            lk          = 1'b1;
         end else begin
            m_state[id] = model_next(m_state[id], w, taps_of[id], m_mode[id]);
            if (m_state[id] == m_ref[id]) begin
               m_cnt[id] = 0;
               pd        = 1'b1;
            end else begin
               m_cnt[id] = (m_cnt[id] + 1) & msk;
            end
         end
      end
      x.out = m_state[id];
      x.cnt = m_cnt[id];
      x.pd  = pd;
      x.lk  = lk;
      x.bo  = m_mode[id] ? m_state[id][0] : m_state[id][w-1];
      if (id == 0) sb0.push_back(x);
      else sb1.push_back(x);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb0.size() != 0) begin
         x = sb0.pop_front();
         check("sb4_out", 32'(out4), x.out);
         check("sb4_step_cnt", 32'(cnt4), x.cnt);
         check("sb4_period_done", 32'(pd4), 32'(x.pd));
         check("sb4_lockup", 32'(lk4), 32'(x.lk));
         check("sb4_bit_out", 32'(bo4), 32'(x.bo));
      end
   end

   always @(posedge clk) begin
      exp_t x;
      #1;
      if (sb1.size() != 0) begin
         x = sb1.pop_front();
         if (pd16 === 1'b1) pd16_seen++;
         if (lk16 === 1'b1) lk16_seen++;
         check("sb16_out", 32'(out16), x.out);
         check("sb16_step_cnt", 32'(cnt16), x.cnt);
         check("sb16_period_done", 32'(pd16), 32'(x.pd));
         check("sb16_lockup", 32'(lk16), 32'(x.lk));
         check("sb16_bit_out", 32'(bo16), 32'(x.bo));
      end
   end

   initial begin
      #1_500_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] fib_exp[3];
      logic [3:0] gal_exp[3];
      int pd_count;
      bit md;

      fib_exp = '{4'b0010, 4'b0100, 4'b1001};
      gal_exp = '{4'b1100, 4'b0110, 4'b0011};

      reset = 1'b0;
      load4 = 0; en4 = 0; mode4 = 0; seed4 = '0;
      load16 = 0; en16 = 0; mode16 = 0; seed16 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("reset_out4", 32'(out4), 32'h1);
      check("reset_cnt4", 32'(cnt4), 32'h0);
      check("reset_pd4", 32'(pd4), 32'h0);
      check("reset_lk4", 32'(lk4), 32'h0);
      check("reset_out16", 32'(out16), 32'h1);
      @(negedge clk);
      reset = 1'b1;

      // Fibonacci from the reset seed.
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b1, 0, 1'b0);
         check("fib_out", 32'(out4), 32'(fib_exp[i]));
         check("fib_bit_out", 32'(bo4), 32'(fib_exp[i][3]));
         check("fib_step_cnt", 32'(cnt4), 32'(i + 1));
      end

      // Galois: load in Fibonacci, then switching mode costs one resync cycle.
      drive(0, 1'b1, 1'b0, 1, 1'b0);
      drive(0, 1'b0, 1'b1, 0, 1'b1);
      check("resync_hold_out", 32'(out4), 32'h1);
      check("resync_step_cnt", 32'(cnt4), 32'h0);
      for (int i = 0; i < 3; i++) begin
         drive(0, 1'b0, 1'b1, 0, 1'b1);
         check("gal_out", 32'(out4), 32'(gal_exp[i]));
         check("gal_bit_out", 32'(bo4), 32'(gal_exp[i][0]));
      end

      // Full period in Fibonacci from seed 1011.
      drive(0, 1'b1, 1'b0, 'hB, 1'b0);
      pd_count = 0;
      for (int i = 0; i < 15; i++) begin
         drive(0, 1'b0, 1'b1, 0, 1'b0);
         if (pd4 === 1'b1) pd_count++;
         check("period_step_cnt", 32'(cnt4), (i < 14) ? 32'(i + 1) : 32'h0);
      end
      check("period_final_out", 32'(out4), 32'hB);
      check("period_pulse_at_end", 32'(pd4), 32'h1);
      check("period_pulse_count", 32'(pd_count), 32'h1);

      // Load beats en.
      drive(0, 1'b1, 1'b1, 'h6, 1'b0);
      check("load_wins_out", 32'(out4), 32'h6);
      check("load_wins_cnt", 32'(cnt4), 32'h0);

      // Mode change while en is held: one hold cycle, then Galois steps.
      drive(0, 1'b0, 1'b1, 0, 1'b1);
      check("toggle_hold_out", 32'(out4), 32'h6);
      drive(0, 1'b0, 1'b1, 0, 1'b1);
      check("toggle_gal_out", 32'(out4), 32'h3);

      // Randomised mix of loads, steps and mode changes.
      md = 1'b1;
      for (int i = 0; i < 400; i++) begin
         bit l, e;
         l = ($urandom_range(0, 15) == 0);
         e = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) md = ~md;
         drive(0, l, e, int'($urandom_range(0, 15)), md);
      end

      // Lockup: zero seed holds without en, recovers on the next step.
      drive(0, 1'b1, 1'b0, 0, 1'b0);
      drive(0, 1'b0, 1'b0, 0, 1'b0);
      drive(0, 1'b0, 1'b0, 0, 1'b0);
      check("zero_holds_out", 32'(out4), 32'h0);
      drive(0, 1'b0, 1'b1, 0, 1'b0);
      check("lockup_out", 32'(out4), 32'h1);
      check("lockup_pulse", 32'(lk4), 32'h1);
      check("lockup_step_cnt", 32'(cnt4), 32'h0);

      // Reset during the lockup pulse clears everything at once.
      #2;
      reset = 1'b0;
      #1;
      check("midreset_out", 32'(out4), 32'h1);
      check("midreset_cnt", 32'(cnt4), 32'h0);
      check("midreset_lockup", 32'(lk4), 32'h0);
      check("midreset_pd", 32'(pd4), 32'h0);
      @(negedge clk);
      load4 = 0; en4 = 0; mode4 = 0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(0, 1'b0, 1'b1, 0, 1'b0);
      check("post_reset_out", 32'(out4), 32'h2);
      @(negedge clk);
      en4 = 0;

      // 16-bit Galois full period from 0xACE1.
      drive(1, 1'b1, 1'b0, 'hACE1, 1'b1);
      for (int i = 0; i < 65535; i++) begin
         drive(1, 1'b0, 1'b1, 0, 1'b1);
      end
      @(negedge clk);
      en16 = 0;
      check("w16_period_count", 32'(pd16_seen), 32'h1);
      check("w16_lockup_count", 32'(lk16_seen), 32'h0);
      check("w16_final_out", 32'(out16), 32'hACE1);
      check("sb_drained", 32'(sb0.size() + sb1.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
